// File: rtl/led_pio_pkg.sv
// Shared constants for the LED PIO: register addresses, reset values and
// STATUS bit positions.
package led_pio_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_SET        = 3'd1;
  localparam logic [2:0] ADDR_CLEAR      = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE     = 3'd3;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd4;
  localparam logic [2:0] ADDR_BLINK_DIV  = 3'd5;
  localparam logic [2:0] ADDR_DUTY       = 3'd6;
  localparam logic [2:0] ADDR_STATUS     = 3'd7;

  // DUTY at full scale bypasses the PWM compare so there is no dark slot.
  localparam logic [7:0] DUTY_FULL = 8'hFF;
  localparam logic [7:0] DUTY_RST  = DUTY_FULL;
  localparam logic       PHASE_RST = 1'b1;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_PWM_BIT   = 1;

endpackage

// File: rtl/led_pio_if.sv
// Avalon-MM slave bus bundle for the LED PIO (zero wait states, zero read latency).
interface led_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led_timebase.sv
// Blink prescaler with phase flip-flop plus a free-running 8-bit PWM counter.
module led_timebase
  import led_pio_pkg::*;
#(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  input  logic             div_load,
  input  logic [7:0]       duty,
  output logic             phase,
  output logic             pwm_on
);

  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       pwm_cnt;

  // A divider load restarts the half-period and wins over a wrap in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      phase   <= PHASE_RST;
    end else if (div_load) begin
      div_cnt <= '0;
      phase   <= PHASE_RST;
    end else if (div_cnt == div) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_on = (duty == DUTY_FULL) || (pwm_cnt < duty);

endmodule

// File: rtl/led_pio_blink.sv
// Avalon-MM LED output PIO: data register with atomic set/clear/toggle,
// per-bit blink masking and global PWM brightness, registered LED drive.
module led_pio_blink
  import led_pio_pkg::*;
#(
  parameter int               WIDTH    = 9,
  parameter int               DIV_W    = 24,
  parameter logic [WIDTH-1:0] DATA_RST = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  led_pio_if.slave         bus,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] blink_mask;
  logic [DIV_W-1:0] blink_div;
  logic [7:0]       duty;
  logic             phase;
  logic             pwm_on;

  logic             wr;
  logic [WIDTH-1:0] wd_led;
  logic [DIV_W-1:0] wd_div;
  logic             wd_unused;

  assign wr        = bus.chipselect && !bus.write_n;
  assign wd_led    = bus.writedata[WIDTH-1:0];
  assign wd_div    = bus.writedata[DIV_W-1:0];
  assign wd_unused = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data       <= DATA_RST;
      blink_mask <= '0;
      blink_div  <= '1;
      duty       <= DUTY_RST;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA:       data       <= wd_led;
        ADDR_SET:        data       <= data | wd_led;
        ADDR_CLEAR:      data       <= data & ~wd_led;
        ADDR_TOGGLE:     data       <= data ^ wd_led;
        ADDR_BLINK_MASK: blink_mask <= wd_led;
        ADDR_BLINK_DIV:  blink_div  <= wd_div;
        ADDR_DUTY:       duty       <= bus.writedata[7:0];
        default:         ;
      endcase
    end
  end

  led_timebase #(
    .DIV_W (DIV_W)
  ) u_timebase (
    .clk      (clk),
    .reset_n  (reset_n),
    .div      (blink_div),
    .div_load (wr && (bus.address == ADDR_BLINK_DIV)),
    .duty     (duty),
    .phase    (phase),
    .pwm_on   (pwm_on)
  );

  // Blinking bits go dark in the low phase; PWM gates every bit together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= '0;
    else          out_port <= data & ~(blink_mask & {WIDTH{~phase}}) & {WIDTH{pwm_on}};
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:       bus.readdata[WIDTH-1:0] = data;
      ADDR_BLINK_MASK: bus.readdata[WIDTH-1:0] = blink_mask;
      ADDR_BLINK_DIV:  bus.readdata[DIV_W-1:0] = blink_div;
      ADDR_DUTY:       bus.readdata[7:0]       = duty;
      ADDR_STATUS: begin
        bus.readdata[STATUS_PHASE_BIT] = phase;
        bus.readdata[STATUS_PWM_BIT]   = pwm_on;
      end
      default:         bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_blink.sv
// Bench for led_pio_blink: directed scenarios then random bus traffic, checked
// against a cycle-count based reference model.
module tb_led_pio_blink;
  localparam int         WIDTH    = 9;
  localparam int         DIV_W    = 24;
  localparam logic [8:0] DATA_RST = 9'h155;
  localparam logic [8:0] ALL      = 9'h1FF;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] out_port;

  led_pio_if bus();

  led_pio_blink #(
    .WIDTH    (WIDTH),
    .DIV_W    (DIV_W),
    .DATA_RST (DATA_RST)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: registers plus elapsed-cycle counts; phase and PWM derived arithmetically.
  logic [8:0] m_data, m_mask, m_out;
  longint     m_div;
  int         m_duty;
  longint     m_t;   // edges since last divider load / reset
  longint     m_n;   // edges since reset

  function automatic bit m_phase();
    return ((m_t / (m_div + 1)) % 2) == 0;
  endfunction

  function automatic bit m_pwm();
    return (m_duty == 255) || ((m_n % 256) < m_duty);
  endfunction

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0:       return {23'd0, m_data};
      4:       return {23'd0, m_mask};
      5:       return 32'(m_div);
      6:       return 32'(m_duty);
      7:       return {30'd0, m_pwm(), m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = DATA_RST; m_mask = '0; m_div = (1 << DIV_W) - 1; m_duty = 255;
    m_t = 0; m_n = 0; m_out = '0;
  endtask

  task automatic step(input bit cs, input bit wn, input int a, input logic [31:0] wd);
    logic [8:0] nxt;
    bit         divw;
    bus.chipselect = cs; bus.write_n = wn; bus.address = a[2:0]; bus.writedata = wd;
    @(posedge clk);
    nxt  = m_data & ~(m_mask & (m_phase() ? 9'h000 : ALL)) & (m_pwm() ? ALL : 9'h000);
    divw = 1'b0;
    if (cs && !wn) begin
      case (a)
        0: m_data = wd[8:0];
        1: m_data = m_data | wd[8:0];
        2: m_data = m_data & ~wd[8:0];
        3: m_data = m_data ^ wd[8:0];
        4: m_mask = wd[8:0];
        5: begin m_div = longint'(wd[DIV_W-1:0]); divw = 1'b1; end
        6: m_duty = int'(wd[7:0]);
        default: ;
      endcase
    end
    if (divw) m_t = 0; else m_t++;
    m_n++;
    m_out = nxt;
    #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    chk("out_port", {23'd0, out_port}, {23'd0, m_out});
  endtask

  task automatic wr(input int a, input logic [31:0] wd);
    step(1'b1, 1'b0, a, wd);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b1, 0, 32'd0);
  endtask

  task automatic rd(input int a, input string tag);
    bus.address = a[2:0]; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1;
    chk(tag, bus.readdata, m_read(a));
    bus.chipselect = 1'b0;
  endtask

  initial begin
    int cnt;
    bit found;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("out_in_reset", {23'd0, out_port}, 32'd0);
    rd(7, "status_in_reset");
    chk("status_const", bus.readdata, 32'h3);
    reset_n = 1'b1;
    idle(1);
    chk("first_out", {23'd0, out_port}, {23'd0, DATA_RST});
    idle(1);
    rd(0, "data_rst"); rd(4, "mask_rst"); rd(5, "div_rst"); rd(6, "duty_rst");

    // Atomic data ops back-to-back
    wr(0, 32'h0F0); wr(1, 32'h003); wr(2, 32'h030); wr(3, 32'h101);
    rd(0, "data_atomic");
    chk("data_atomic_val", bus.readdata, 32'h1C2);
    idle(1);
    chk("out_atomic_val", {23'd0, out_port}, 32'h1C2);

    // Unmapped reads and ignored writes
    rd(1, "rd_set"); rd(2, "rd_clear"); rd(3, "rd_toggle");
    step(1'b0, 1'b0, 0, 32'h000);
    rd(0, "data_cs_low");
    step(1'b1, 1'b1, 0, 32'h000);
    rd(0, "data_wn_high");
    wr(7, 32'hFFFF_FFFF);
    rd(7, "status_after_wr");

    // Blink: DIV=3, bit0 blinking
    wr(0, 32'h1FF); wr(4, 32'h001); wr(5, 32'd3);
    for (int i = 0; i < 4; i++) begin
      rd(7, "phase_early");
      chk("phase_early_hi", {31'd0, bus.readdata[0]}, 32'd1);
      idle(1);
    end
    rd(7, "phase_low");
    chk("phase_low_val", {31'd0, bus.readdata[0]}, 32'd0);
    idle(20);

    // Divider reload while in the low phase
    wr(5, 32'd5);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle(1);
      rd(7, "wait_phase");
      if (bus.readdata[0] == 1'b0) found = 1'b1;
    end
    chk("phase0_seen", {31'd0, found}, 32'd1);
    idle(2);
    wr(5, 32'd5);
    rd(7, "reload_phase");
    chk("reload_phase_hi", {31'd0, bus.readdata[0]}, 32'd1);
    idle(14);

    // PWM brightness
    wr(4, 32'h000); wr(6, 32'd64);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      if (out_port == ALL) cnt++;
    end
    chk("duty64_count", cnt, 64);
    wr(6, 32'd0);
    idle(256);
    wr(6, 32'd255);
    idle(256);

    // Asynchronous reset mid-count
    wr(5, 32'd7); wr(0, 32'h0AA); idle(3);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_out", {23'd0, out_port}, 32'd0);
    rd(0, "async_rst_data");
    rd(5, "async_rst_div");
    rd(7, "async_rst_status");
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      int a;
      logic [31:0] wd;
      a  = $urandom_range(0, 7);
      wd = $urandom;
      if (a == 5) wd = $urandom_range(0, 6);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, a, wd);
      rd($urandom_range(0, 7), "rand_read");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
